// File: rtl/ddr3_reset_n_seq.sv
// DDR3 RESET_N lane power-up sequencer: loads and trims the IOD delay line, holds
// RESET_N low, releases it, waits out the reset-to-CKE interval, then grants CKE.
module ddr3_reset_n_seq #(
    parameter int RST_LOW_CYC  = 20000,
    parameter int CKE_WAIT_CYC = 50000,
    parameter int TAP_STEPS    = 0
) (
    input  logic       FAB_CLK,
    input  logic       ARST_N,
    input  logic       START,
    input  logic       TAP_DIR,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic [3:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    output logic       DELAY_LINE_LOAD_0,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       CKE_EN,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam int MAX_CYC = (RST_LOW_CYC > CKE_WAIT_CYC) ? RST_LOW_CYC : CKE_WAIT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counters hold "cycles remaining after this one", so they are loaded with N-1.
    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] CKE_WAIT_LAST = CNT_W'(CKE_WAIT_CYC - 1);
    localparam logic [7:0]       TAP_LAST      = 8'(TAP_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIM,
        S_RST_LOW,
        S_RST_WAIT,
        S_READY
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tap_cnt;
    logic [3:0]       r_tx;
    logic [3:0]       r_oe;
    logic             r_load;
    logic             r_move;
    logic             r_dir;
    logic             r_cke;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tap_cnt <= '0;
            r_tx      <= 4'h0;
            r_oe      <= 4'hF;
            r_load    <= 1'b0;
            r_move    <= 1'b0;
            r_dir     <= 1'b0;
            r_cke     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_oe   <= 4'hF;
            r_load <= 1'b0;
            r_move <= 1'b0;
            case (r_state)
                S_IDLE, S_READY: begin
                    if (START) begin
                        r_state <= S_LOAD;
                        r_load  <= 1'b1;
                        r_tx    <= 4'h0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_cke   <= 1'b0;
                        r_err   <= 1'b0;
                        r_dir   <= TAP_DIR;
                    end
                end
                S_LOAD: begin
                    if (TAP_STEPS > 0) begin
                        r_state   <= S_TRIM;
                        r_move    <= 1'b1;
                        r_tap_cnt <= TAP_LAST;
                    end else begin
                        r_state <= S_RST_LOW;
                        r_cnt   <= RST_LOW_LAST;
                    end
                end
                S_TRIM: begin
                    // Saturation aborts the trim; a pulse on the wire this cycle still ends normally.
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        r_err   <= 1'b1;
                        r_state <= S_RST_LOW;
                        r_cnt   <= RST_LOW_LAST;
                    end else if (!r_move) begin
                        if (r_tap_cnt == 8'd0) begin
                            r_state <= S_RST_LOW;
                            r_cnt   <= RST_LOW_LAST;
                        end else begin
                            r_move    <= 1'b1;
                            r_tap_cnt <= r_tap_cnt - 8'd1;
                        end
                    end
                end
                S_RST_LOW: begin
                    if (r_cnt == '0) begin
                        r_state <= S_RST_WAIT;
                        r_tx    <= 4'hF;
                        r_cnt   <= CKE_WAIT_LAST;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cke   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign TX_DATA_0              = r_tx;
    assign OE_DATA_0              = r_oe;
    assign DELAY_LINE_LOAD_0      = r_load;
    assign DELAY_LINE_MOVE_0      = r_move;
    assign DELAY_LINE_DIRECTION_0 = r_dir;
    assign CKE_EN                 = r_cke;
    assign BUSY                   = r_busy;
    assign DONE                   = r_done;
    assign ERR                    = r_err;

endmodule

// File: tb/tb_ddr3_reset_n_seq.sv
// Bench for ddr3_reset_n_seq: two instances (TAP_STEPS=3 and 0) checked every cycle
// against a timeline model, plus literal checks at the key cycles of each scenario.
module tb_ddr3_reset_n_seq;
    localparam int R  = 8;
    localparam int W  = 12;
    localparam int TA = 3;
    localparam int TB = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic tap_dir = 1'b0;
    logic oor   = 1'b0;

    logic [3:0] tx [2];
    logic [3:0] oe [2];
    logic load [2], move [2], dirq [2], cke [2], busy [2], done [2], err [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    ddr3_reset_n_seq #(.RST_LOW_CYC(R), .CKE_WAIT_CYC(W), .TAP_STEPS(TA)) dut_a (
        .FAB_CLK(clk), .ARST_N(rst_n), .START(start), .TAP_DIR(tap_dir),
        .DELAY_LINE_OUT_OF_RANGE_0(oor),
        .TX_DATA_0(tx[0]), .OE_DATA_0(oe[0]), .DELAY_LINE_LOAD_0(load[0]),
        .DELAY_LINE_MOVE_0(move[0]), .DELAY_LINE_DIRECTION_0(dirq[0]),
        .CKE_EN(cke[0]), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    ddr3_reset_n_seq #(.RST_LOW_CYC(R), .CKE_WAIT_CYC(W), .TAP_STEPS(TB)) dut_b (
        .FAB_CLK(clk), .ARST_N(rst_n), .START(start), .TAP_DIR(tap_dir),
        .DELAY_LINE_OUT_OF_RANGE_0(oor),
        .TX_DATA_0(tx[1]), .OE_DATA_0(oe[1]), .DELAY_LINE_LOAD_0(load[1]),
        .DELAY_LINE_MOVE_0(move[1]), .DELAY_LINE_DIRECTION_0(dirq[1]),
        .CKE_EN(cke[1]), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    function automatic int tsteps(input int i);
        return (i == 0) ? TA : TB;
    endfunction

    function automatic void chk(input string nm, input int i, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, i, $time, got, exp);
        end
    endfunction

    // Model: each run is a timeline measured from its accepting edge; the trim
    // length shrinks when a saturation flag cuts it short.
    int  m = 0;
    int  mk;
    bit  act [2] = '{1'b0, 1'b0};
    int  e [2]   = '{0, 0};
    int  tl [2]  = '{0, 0};
    bit  merr [2] = '{1'b0, 1'b0};
    bit  mdir [2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 1'b0; merr[i] = 1'b0; mdir[i] = 1'b0;
            end
        end else begin
            m++;
            for (int i = 0; i < 2; i++) begin
                mk = m - e[i];
                if (!act[i] || mk >= 2 + tl[i] + R + W) begin
                    if (start) begin
                        act[i] = 1'b1; e[i] = m; tl[i] = 2 * tsteps(i);
                        merr[i] = 1'b0; mdir[i] = tap_dir;
                    end
                end else if (mk >= 2 && mk <= 1 + tl[i] && oor) begin
                    tl[i] = mk - 1;
                    merr[i] = 1'b1;
                end
            end
        end
    end

    function automatic void model_out(input int i, output logic [3:0] etx, output logic eload,
                                      output logic emove, output logic ebusy, output logic edone);
        int k, len;
        etx = 4'h0; eload = 1'b0; emove = 1'b0; ebusy = 1'b0; edone = 1'b0;
        if (act[i]) begin
            k   = m - e[i] + 1;
            len = 1 + tl[i] + R + W;
            eload = (k == 1);
            emove = (k >= 2) && (k <= 1 + tl[i]) && (k % 2 == 0);
            etx   = (k >= 2 + tl[i] + R) ? 4'hF : 4'h0;
            ebusy = (k <= len);
            edone = (k > len);
        end
    endfunction

    logic [3:0] x_tx;
    logic x_load, x_move, x_busy, x_done;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            model_out(i, x_tx, x_load, x_move, x_busy, x_done);
            chk("tx",   i, 8'(tx[i]),   8'(x_tx));
            chk("oe",   i, 8'(oe[i]),   8'hF);
            chk("load", i, 8'(load[i]), 8'(x_load));
            chk("move", i, 8'(move[i]), 8'(x_move));
            chk("dir",  i, 8'(dirq[i]), 8'(mdir[i]));
            chk("cke",  i, 8'(cke[i]),  8'(x_done));
            chk("busy", i, 8'(busy[i]), 8'(x_busy));
            chk("done", i, 8'(done[i]), 8'(x_done));
            chk("err",  i, 8'(err[i]),  8'(merr[i]));
        end
    end

    logic [3:0] h_tx [2][64];
    logic h_load [2][64], h_move [2][64], h_cke [2][64], h_done [2][64], h_err [2][64], h_dir [2][64];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic record();
        if (cyc < 64) begin
            for (int i = 0; i < 2; i++) begin
                h_tx[i][cyc] = tx[i]; h_load[i][cyc] = load[i]; h_move[i][cyc] = move[i];
                h_cke[i][cyc] = cke[i]; h_done[i][cyc] = done[i]; h_err[i][cyc] = err[i];
                h_dir[i][cyc] = dirq[i];
            end
        end
    endtask

    // Accepting edge is cycle 0; inputs set while in period c are sampled at edge c.
    task automatic run_seq(input int ncyc, input int oor_c, input int s_a, input int s_b, input logic dirv);
        tap_dir = dirv; start = 1'b1; cyc = 0;
        tick(); record();
        start = 1'b0;
        while (cyc < ncyc) begin
            oor     = (cyc == oor_c);
            start   = (cyc == s_a) || (cyc == s_b);
            tap_dir = 1'($urandom);
            tick(); record();
        end
        oor = 1'b0; start = 1'b0;
    endtask

    function automatic int nmove(input int i);
        int n = 0;
        for (int c = 1; c <= 30; c++) n += int'(h_move[i][c]);
        return n;
    endfunction

    int act_cnt;

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", i, 8'(tx[i]), 8'h0);
            chk("rst_oe", i, 8'(oe[i]), 8'hF);
            chk("rst_busy", i, 8'(busy[i]), 8'h0);
        end
        #2 rst_n = 1'b1;

        // Nominal run from IDLE, TAP_DIR=1.
        run_seq(30, -1, -1, -1, 1'b1);
        chk("s1_load_c1", 0, 8'(h_load[0][1]), 8'h1);
        chk("s1_load_c2", 0, 8'(h_load[0][2]), 8'h0);
        chk("s1_move_c2", 0, 8'(h_move[0][2]), 8'h1);
        chk("s1_move_c4", 0, 8'(h_move[0][4]), 8'h1);
        chk("s1_move_c6", 0, 8'(h_move[0][6]), 8'h1);
        chk("s1_move_c7", 0, 8'(h_move[0][7]), 8'h0);
        chk("s1_nmove",   0, 8'(nmove(0)), 8'd3);
        chk("s1_dir_c1",  0, 8'(h_dir[0][1]), 8'h1);
        chk("s1_tx_c15",  0, 8'(h_tx[0][15]), 8'h0);
        chk("s1_tx_c16",  0, 8'(h_tx[0][16]), 8'hF);
        chk("s1_done_c27", 0, 8'(h_done[0][27]), 8'h0);
        chk("s1_done_c28", 0, 8'(h_done[0][28]), 8'h1);
        chk("s1_cke_c28", 0, 8'(h_cke[0][28]), 8'h1);
        chk("s1_err_c28", 0, 8'(h_err[0][28]), 8'h0);
        chk("s1_load_c1", 1, 8'(h_load[1][1]), 8'h1);
        chk("s1_nmove",   1, 8'(nmove(1)), 8'd0);
        chk("s1_tx_c9",   1, 8'(h_tx[1][9]), 8'h0);
        chk("s1_tx_c10",  1, 8'(h_tx[1][10]), 8'hF);
        chk("s1_done_c21", 1, 8'(h_done[1][21]), 8'h0);
        chk("s1_done_c22", 1, 8'(h_done[1][22]), 8'h1);

        // Restart from READY with saturation in cycle 3.
        run_seq(30, 3, -1, -1, 1'b0);
        chk("s2_cke_c1",  0, 8'(h_cke[0][1]), 8'h0);
        chk("s2_done_c1", 0, 8'(h_done[0][1]), 8'h0);
        chk("s2_tx_c1",   0, 8'(h_tx[0][1]), 8'h0);
        chk("s2_move_c2", 0, 8'(h_move[0][2]), 8'h1);
        chk("s2_nmove",   0, 8'(nmove(0)), 8'd1);
        chk("s2_err_c3",  0, 8'(h_err[0][3]), 8'h0);
        chk("s2_err_c4",  0, 8'(h_err[0][4]), 8'h1);
        chk("s2_tx_c11",  0, 8'(h_tx[0][11]), 8'h0);
        chk("s2_tx_c12",  0, 8'(h_tx[0][12]), 8'hF);
        chk("s2_done_c23", 0, 8'(h_done[0][23]), 8'h0);
        chk("s2_done_c24", 0, 8'(h_done[0][24]), 8'h1);
        chk("s2_err_c22", 1, 8'(h_err[1][22]), 8'h0);
        chk("s2_done_c22", 1, 8'(h_done[1][22]), 8'h1);

        // START pulses at 5 and 20 while busy must not disturb the timeline; ERR clears.
        run_seq(30, -1, 5, 20, 1'b1);
        chk("s3_err_c1",  0, 8'(h_err[0][1]), 8'h0);
        chk("s3_dir_c1",  0, 8'(h_dir[0][1]), 8'h1);
        chk("s3_nmove",   0, 8'(nmove(0)), 8'd3);
        chk("s3_tx_c15",  0, 8'(h_tx[0][15]), 8'h0);
        chk("s3_tx_c16",  0, 8'(h_tx[0][16]), 8'hF);
        chk("s3_done_c27", 0, 8'(h_done[0][27]), 8'h0);
        chk("s3_done_c28", 0, 8'(h_done[0][28]), 8'h1);
        chk("s3_done_c22", 1, 8'(h_done[1][22]), 8'h1);

        // Asynchronous reset in cycle 18 (RESET_N already released).
        tap_dir = 1'b1; start = 1'b1; cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 18) tick();
        chk("s4_tx_pre", 0, 8'(tx[0]), 8'hF);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("s4_tx",   i, 8'(tx[i]), 8'h0);
            chk("s4_oe",   i, 8'(oe[i]), 8'hF);
            chk("s4_cke",  i, 8'(cke[i]), 8'h0);
            chk("s4_busy", i, 8'(busy[i]), 8'h0);
            chk("s4_done", i, 8'(done[i]), 8'h0);
            chk("s4_err",  i, 8'(err[i]), 8'h0);
            chk("s4_dir",  i, 8'(dirq[i]), 8'h0);
        end
        tick(); tick();
        #2 rst_n = 1'b1;
        act_cnt = 0;
        repeat (40) begin
            tap_dir = 1'($urandom);
            oor = 1'($urandom);
            tick();
            for (int i = 0; i < 2; i++)
                act_cnt += int'(load[i]) + int'(move[i]) + int'(busy[i]) + int'(tx[i] != 4'h0);
        end
        oor = 1'b0;
        chk("s4_idle_activity", 0, 8'(act_cnt), 8'd0);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            start   = ($urandom_range(0, 39) == 0);
            tap_dir = 1'($urandom);
            oor     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 rst_n = 1'b0;
                tick();
                #2 rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        start = 1'b0; oor = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_reset_n_seq.md
# ddr3_reset_n_seq

Power-up sequencer for the DDR3 RESET_N I/O lane. It runs in the fabric clock domain and drives the 4:1 TX/OE data and dynamic delay-line controls of the RESET_N IOD. On each start request it loads and trims the output delay line. It then holds DRAM RESET_N low for the JEDEC minimum, releases it, and counts the reset-to-CKE wait. Finally it grants CKE to the DDR controller.

## Interface
Parameters:
- RST_LOW_CYC, 20000: cycles RESET_N is held low after trimming (200 us at 100 MHz); legal range ≥1.
- CKE_WAIT_CYC, 50000: cycles from RESET_N release to CKE grant (500 us); legal range ≥1.
- TAP_STEPS, 0: number of delay-line MOVE pulses issued after LOAD; legal range 0..255.

Ports:
- FAB_CLK  in  1  fabric clock; the only clock.
- ARST_N  in  1  asynchronous, active-low reset.
- START  in  1  request to begin or restart the sequence.
- TAP_DIR  in  1  trim direction; latched when START is accepted.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  IOD delay-line saturation flag.
- TX_DATA_0  out  4  serialized RESET_N level; all four bits are equal.
- OE_DATA_0  out  4  output enable; constant 4'hF.
- DELAY_LINE_LOAD_0  out  1  one-cycle load pulse.
- DELAY_LINE_MOVE_0  out  1  one-cycle tap-move pulse.
- DELAY_LINE_DIRECTION_0  out  1  latched TAP_DIR.
- CKE_EN  out  1  DRAM CKE may be raised.
- BUSY  out  1  sequence in progress.
- DONE  out  1  sequence complete.
- ERR  out  1  sticky flag: out-of-range seen during trim.

## Operation
- All outputs are registered.
- Reset values: TX_DATA_0=4'h0, OE_DATA_0=4'hF, LOAD=0, MOVE=0, DIRECTION=0, CKE_EN=0, BUSY=0, DONE=0, ERR=0. State resets to IDLE.
- RESET_N level (TX_DATA_0) is 4'h0 in IDLE, LOAD, TRIM and RST_LOW. It is 4'hF in RST_WAIT and READY.
- IDLE: waits for START=1, then goes to LOAD. On acceptance, DIRECTION latches TAP_DIR and ERR clears.
- LOAD: DELAY_LINE_LOAD_0=1 for one cycle. Next state is TRIM if TAP_STEPS>0, otherwise RST_LOW.
- TRIM: alternates cycles of MOVE=1 and MOVE=0. It issues exactly TAP_STEPS pulses, taking 2·TAP_STEPS cycles, then goes to RST_LOW.
- Out-of-range during TRIM:
  - DELAY_LINE_OUT_OF_RANGE_0 is sampled every TRIM cycle.
  - If it is high, ERR=1 next cycle, MOVE=0 from then on, and the state goes to RST_LOW next cycle.
  - A MOVE pulse already being driven completes.
- RST_LOW: down-counter loaded with RST_LOW_CYC. The state lasts RST_LOW_CYC cycles, then goes to RST_WAIT.
- RST_WAIT: counter reloads with CKE_WAIT_CYC. The state lasts CKE_WAIT_CYC cycles, then goes to READY.
- READY: CKE_EN=1 and DONE=1. START=1 returns the block to LOAD, with the same effects as acceptance in IDLE. In the following cycle TX_DATA_0=4'h0 and CKE_EN=DONE=0.
- START during LOAD, TRIM, RST_LOW or RST_WAIT is ignored.
- BUSY=1 in LOAD, TRIM, RST_LOW and RST_WAIT.
- Counter width is $clog2(max(RST_LOW_CYC, CKE_WAIT_CYC)+1). The tap counter is 8 bits. No wrap can occur within legal parameters.
- ARST_N assertion mid-sequence:
  - All outputs return to their reset values immediately (asynchronously).
  - TX_DATA_0 goes to 4'h0, so the DRAM is re-held in reset.
  - The full sequence restarts only on a new START.

## Timing
- Cycle 0 is the edge that samples START=1. T=TAP_STEPS, R=RST_LOW_CYC, W=CKE_WAIT_CYC.
- LOAD high: cycle 1.
- MOVE high: cycles 2, 4, …, 2T.
- RST_LOW: cycles 2+2T .. 1+2T+R.
- TX_DATA_0=4'hF: from cycle 2+2T+R.
- CKE_EN/DONE=1 and BUSY=0: from cycle 2+2T+R+W.
- Out-of-range sampled in cycle k of TRIM: ERR and RST_LOW from cycle k+1, and the R count starts at k+1.
- Restart from READY at cycle 0: TX_DATA_0=4'h0 and CKE_EN=0 at cycle 1.

## Test plan
- Parameters R=8, W=12, T=3, TAP_DIR=1; START pulse at cycle 0:
  - LOAD at cycle 1; MOVE at cycles 2, 4, 6; DIRECTION=1.
  - TX_DATA_0=4'hF at cycle 16; CKE_EN=DONE=1 at cycle 28; ERR=0.
- T=0: LOAD at cycle 1, no MOVE pulses, TX_DATA_0=4'hF at cycle 10, DONE at cycle 22.
- T=3, OUT_OF_RANGE forced high in cycle 3:
  - Only the MOVE pulse at cycle 2 is issued; ERR=1 from cycle 4.
  - TX_DATA_0=4'hF at cycle 12, DONE at cycle 24.
  - ERR clears on the next START.
- START pulses at cycles 5 and 20 during BUSY are ignored; timing is identical to the first scenario.
- START in READY: CKE_EN and DONE drop and TX_DATA_0=4'h0 next cycle; the full sequence repeats with the same offsets.
- ARST_N low at cycle 18:
  - TX_DATA_0=4'h0 and CKE_EN, BUSY, DONE, ERR all 0 asynchronously.
  - The block stays in IDLE with no MOVE/LOAD activity until a new START.
